// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cpu_pkg                                                |
// | Description : Shared control-transfer types and LEGv8 condition     |
// |               codes for the ID-stage branch logic.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // Control-transfer kind decoded in ID; encodings 6 and 7 behave as NONE.
  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_BCOND = 3'd2,
    BR_CBZ   = 3'd3,
    BR_CBNZ  = 3'd4,
    BR_BR    = 3'd5
  } br_type_e;

  // LEGv8 condition codes carried in the B.cond encoding.
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cond_eval                                              |
// | Description : Combinational LEGv8 condition-code evaluator.          |
// |               Shared by branch resolution and conditional select.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       taken
);

  // Decode the condition code against the current NZCV flags.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_HS: taken = c;
      COND_LO: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : branch_resolve_unit                                    |
// | Description : Resolves ID-stage control transfers, stalls on pending |
// |               flag writes, drives the IF/ID flush window and keeps   |
// |               saturating branch / taken-branch counters.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic [2:0]        br_type,
  input  logic [3:0]        cond,
  input  logic              rt_zero,
  input  logic              negFlag,
  input  logic              zeroFlag,
  input  logic              overflowFlag,
  input  logic              carry_outFlag,
  input  logic              ex_sets_flags,
  input  logic [ADDR_W-1:0] pc_id,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] reg_target,
  output logic              stall,
  output logic              resolve_valid,
  output logic              taken,
  output logic [ADDR_W-1:0] target_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [2:0]       C_FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [2:0]        r_fcnt;
  logic              w_stall;
  logic              w_resolve;
  logic              w_cond_taken;
  logic              w_taken;
  logic              w_type_valid;
  logic              w_is_bcond;
  logic [ADDR_W-1:0] w_target;

  cond_eval u_cond_eval (
    .cond  (cond),
    .n     (negFlag),
    .z     (zeroFlag),
    .c     (carry_outFlag),
    .v     (overflowFlag),
    .taken (w_cond_taken)
  );

  // Classify the ID instruction and compute its outcome and target.
  always_comb begin
    w_type_valid = 1'b0;
    w_is_bcond   = 1'b0;
    w_taken      = 1'b0;
    case (br_type)
      BR_B:     begin w_type_valid = 1'b1; w_taken = 1'b1; end
      BR_BCOND: begin w_type_valid = 1'b1; w_is_bcond = 1'b1; w_taken = w_cond_taken; end
      BR_CBZ:   begin w_type_valid = 1'b1; w_taken = rt_zero; end
      BR_CBNZ:  begin w_type_valid = 1'b1; w_taken = ~rt_zero; end
      BR_BR:    begin w_type_valid = 1'b1; w_taken = 1'b1; end
      default:  begin w_type_valid = 1'b0; w_taken = 1'b0; end
    endcase
    // Offsets are word counts; the add wraps modulo 2^ADDR_W.
    w_target = (br_type == BR_BR) ? reg_target : (pc_id + (br_offset << 2));
  end

  // Next-state, stall and resolve decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_id && w_type_valid) begin
          if (w_is_bcond && ex_sets_flags) begin
            w_stall     = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_resolve = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!valid_id) begin
          w_state_nxt = S_IDLE;
        end else if (ex_sets_flags) begin
          w_stall = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_resolve   = w_type_valid;
        end
      end
      S_FLUSH: begin
        // Wrong-path ID contents are ignored until the window closes.
        if (r_fcnt <= 3'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_resolve && w_taken) begin
      w_state_nxt = S_FLUSH;
    end
  end

  // Stall must stay low while reset is held, whatever ID presents.
  assign stall = w_stall & reset;

  // FSM state and flush-window counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_fcnt  <= 3'd0;
      flush   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      flush   <= (w_state_nxt == S_FLUSH);
      if (w_resolve && w_taken) begin
        r_fcnt <= C_FLUSH_INIT;
      end else if (r_state == S_FLUSH && r_fcnt != 3'd0) begin
        r_fcnt <= r_fcnt - 3'd1;
      end
    end
  end

  // Registered outcome: a one-cycle pulse with outcome and target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resolve_valid <= 1'b0;
      taken         <= 1'b0;
      target_pc     <= '0;
    end else begin
      resolve_valid <= w_resolve;
      if (w_resolve) begin
        taken     <= w_taken;
        target_pc <= w_target;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (w_resolve) begin
      if (br_count != C_CNT_MAX) begin
        br_count <= br_count + 1'b1;
      end
      if (w_taken && taken_count != C_CNT_MAX) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_branch_resolve_unit                                 |
// | Description : Self-checking bench for branch_resolve_unit. Three     |
// |               instances (FLUSH 1/32b, FLUSH 3/32b, FLUSH 1/4b) share |
// |               the stimulus and are checked against a flag model.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_id;
  logic [2:0]  br_type;
  logic [3:0]  cond;
  logic        rt_zero, nf, zf, vf, cf, ex_sets_flags;
  logic [63:0] pc_id, br_offset, reg_target;

  logic        stall_a [3];
  logic        rv_a    [3];
  logic        tk_a    [3];
  logic        fl_a    [3];
  logic [63:0] tgt_a   [3];
  logic [31:0] br_a    [3];
  logic [31:0] tc_a    [3];
  logic [3:0]  br4, tc4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.ADDR_W(64), .FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .valid_id(valid_id), .br_type(br_type), .cond(cond),
    .rt_zero(rt_zero), .negFlag(nf), .zeroFlag(zf), .overflowFlag(vf), .carry_outFlag(cf),
    .ex_sets_flags(ex_sets_flags), .pc_id(pc_id), .br_offset(br_offset), .reg_target(reg_target),
    .stall(stall_a[0]), .resolve_valid(rv_a[0]), .taken(tk_a[0]), .target_pc(tgt_a[0]),
    .flush(fl_a[0]), .br_count(br_a[0]), .taken_count(tc_a[0]));

  branch_resolve_unit #(.ADDR_W(64), .FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .valid_id(valid_id), .br_type(br_type), .cond(cond),
    .rt_zero(rt_zero), .negFlag(nf), .zeroFlag(zf), .overflowFlag(vf), .carry_outFlag(cf),
    .ex_sets_flags(ex_sets_flags), .pc_id(pc_id), .br_offset(br_offset), .reg_target(reg_target),
    .stall(stall_a[1]), .resolve_valid(rv_a[1]), .taken(tk_a[1]), .target_pc(tgt_a[1]),
    .flush(fl_a[1]), .br_count(br_a[1]), .taken_count(tc_a[1]));

  branch_resolve_unit #(.ADDR_W(64), .FLUSH_CYCLES(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid_id(valid_id), .br_type(br_type), .cond(cond),
    .rt_zero(rt_zero), .negFlag(nf), .zeroFlag(zf), .overflowFlag(vf), .carry_outFlag(cf),
    .ex_sets_flags(ex_sets_flags), .pc_id(pc_id), .br_offset(br_offset), .reg_target(reg_target),
    .stall(stall_a[2]), .resolve_valid(rv_a[2]), .taken(tk_a[2]), .target_pc(tgt_a[2]),
    .flush(fl_a[2]), .br_count(br4), .taken_count(tc4));

  assign br_a[2] = {28'd0, br4};
  assign tc_a[2] = {28'd0, tc4};

  // ---------------- behavioural model ----------------
  int          m_fleft [3];
  bit          m_hold  [3];
  bit          m_rv    [3];
  bit          m_tk    [3];
  logic [63:0] m_tgt   [3];
  longint      m_br    [3];
  longint      m_tc    [3];

  function automatic int flen(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic longint cap(int k);
    return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  // ARM-style: even code picks a base predicate, odd code inverts it (AL/NV both true).
  function automatic bit m_cond(logic [3:0] c, bit n, bit z, bit cy, bit v);
    bit b;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return (c[0] && c != 4'd15) ? !b : b;
  endfunction

  function automatic bit m_taken();
    case (br_type)
      3'd1, 3'd5: return 1'b1;
      3'd2: return m_cond(cond, nf, zf, cf, vf);
      3'd3: return rt_zero;
      3'd4: return !rt_zero;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_stall(int k);
    if (!reset || m_fleft[k] != 0 || !valid_id) return 1'b0;
    return m_hold[k] ? ex_sets_flags : (br_type == 3'd2 && ex_sets_flags);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_fleft[k] = 0; m_hold[k] = 0; m_rv[k] = 0; m_tk[k] = 0;
      m_tgt[k] = '0; m_br[k] = 0; m_tc[k] = 0;
    end
  endtask

  always @(negedge reset) m_reset();

  always @(posedge clk) begin
    if (!reset) begin
      m_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit st, res, tk;
        st  = m_stall(k);
        res = (m_fleft[k] == 0) && valid_id && (br_type >= 3'd1 && br_type <= 3'd5) && !st;
        m_rv[k] = res;
        if (res) begin
          tk = m_taken();
          m_tk[k]  = tk;
          m_tgt[k] = (br_type == 3'd5) ? reg_target : pc_id + br_offset * 64'd4;
          if (m_br[k] < cap(k)) m_br[k]++;
          if (tk && m_tc[k] < cap(k)) m_tc[k]++;
          m_fleft[k] = tk ? flen(k) : 0;
        end else if (m_fleft[k] > 0) begin
          m_fleft[k]--;
        end
        m_hold[k] = st;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare every instance against the model away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("cmp%0d_stall", k), 64'(stall_a[k]), 64'(m_stall(k)));
        chk($sformatf("cmp%0d_rv", k), 64'(rv_a[k]), 64'(m_rv[k]));
        chk($sformatf("cmp%0d_flush", k), 64'(fl_a[k]), 64'(m_fleft[k] > 0));
        chk($sformatf("cmp%0d_brcnt", k), 64'(br_a[k]), 64'(m_br[k]));
        chk($sformatf("cmp%0d_tkcnt", k), 64'(tc_a[k]), 64'(m_tc[k]));
        if (m_rv[k]) begin
          chk($sformatf("cmp%0d_taken", k), 64'(tk_a[k]), 64'(m_tk[k]));
          if (m_tk[k]) chk($sformatf("cmp%0d_target", k), tgt_a[k], m_tgt[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic go();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    valid_id = 0; br_type = 3'd0; cond = 4'd0; rt_zero = 0;
    nf = 0; zf = 0; vf = 0; cf = 0; ex_sets_flags = 0;
    pc_id = '0; br_offset = '0; reg_target = '0;
  endtask

  task automatic gap(int n);
    idle();
    repeat (n) go();
  endtask

  task automatic drive(input logic [2:0] t, input logic [3:0] c, input logic [3:0] nzcv,
                       input logic ex, input logic [63:0] pc, input logic [63:0] off);
    valid_id = 1; br_type = t; cond = c;
    nf = nzcv[3]; zf = nzcv[2]; cf = nzcv[1]; vf = nzcv[0];
    ex_sets_flags = ex; pc_id = pc; br_offset = off;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 0;
    m_reset();
    // Stall must stay low under reset even for a flag-dependent B.cond.
    drive(3'd2, 4'd0, 4'b0000, 1'b1, 64'h0, 64'h0);
    #1 chk("rst_stall", 64'(stall_a[0]), 64'd0);
    idle();
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_rv", 64'(rv_a[0]), 64'd0);
    chk("rst_flush", 64'(fl_a[1]), 64'd0);
    chk("rst_brcnt", 64'(br_a[0]), 64'd0);
    chk("rst_target", tgt_a[0], 64'd0);
    #1;

    // B.cond EQ taken with Z=1.
    drive(3'd2, 4'd0, 4'b0100, 1'b0, 64'h1000, 64'd4);
    @(posedge clk); #1;
    chk("eq_rv", 64'(rv_a[0]), 64'd1);
    chk("eq_taken", 64'(tk_a[0]), 64'd1);
    chk("eq_target", tgt_a[0], 64'h1010);
    chk("eq_flush", 64'(fl_a[0]), 64'd1);
    chk("eq_brcnt", 64'(br_a[0]), 64'd1);
    chk("eq_tkcnt", 64'(tc_a[0]), 64'd1);
    #1 idle();
    @(posedge clk); #1;
    chk("eq_flush_end", 64'(fl_a[0]), 64'd0);
    chk("eq_rv_pulse", 64'(rv_a[0]), 64'd0);
    #1 gap(4);

    // B.cond GT held by pending flag writes, then taken, then not taken with Z=1.
    for (int run = 0; run < 2; run++) begin
      drive(3'd2, 4'd12, 4'b0000, 1'b1, 64'h2000, 64'd8);
      #1 chk("gt_stall0", 64'(stall_a[0]), 64'd1);
      @(posedge clk); #1;
      chk("gt_stall1", 64'(stall_a[0]), 64'd1);
      chk("gt_norv", 64'(rv_a[0]), 64'd0);
      @(posedge clk); #2;
      ex_sets_flags = 0;
      zf = (run == 1);
      #1 chk("gt_stall2", 64'(stall_a[0]), 64'd0);
      @(posedge clk); #1;
      chk("gt_rv", 64'(rv_a[0]), 64'd1);
      chk("gt_taken", 64'(tk_a[0]), (run == 0) ? 64'd1 : 64'd0);
      if (run == 1) begin
        chk("gt_nt_flush", 64'(fl_a[0]), 64'd0);
        chk("gt_nt_brcnt", 64'(br_a[0]), 64'd3);
        chk("gt_nt_tkcnt", 64'(tc_a[0]), 64'd2);
      end
      #1 gap(4);
    end

    // Full condition sweep; the model checks each outcome.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(3'd2, 4'(c), 4'(f), 1'b0, 64'(c * 256), 64'(f));
        go();
        gap(4);
      end
    end

    // CBZ / CBNZ with Rt==0; ex_sets_flags is ignored for non-B.cond.
    drive(3'd3, 4'd0, 4'b0000, 1'b1, 64'h3000, 64'd1);
    rt_zero = 1;
    #1 chk("cbz_nostall", 64'(stall_a[0]), 64'd0);
    @(posedge clk); #1;
    chk("cbz_taken", 64'(tk_a[0]), 64'd1);
    #1 gap(4);
    drive(3'd4, 4'd0, 4'b0000, 1'b0, 64'h3000, 64'd1);
    rt_zero = 1;
    @(posedge clk); #1;
    chk("cbnz_taken", 64'(tk_a[0]), 64'd0);
    #1 gap(4);

    // BR right after reset release, valid B inside the 3-cycle flush window.
    reset = 0;
    go();
    reset = 1;
    drive(3'd5, 4'd0, 4'b0000, 1'b0, 64'h4000, 64'd0);
    reg_target = 64'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("br_target", tgt_a[1], 64'hDEAD_BEEF);
    chk("br_flush1", 64'(fl_a[1]), 64'd1);
    #1 drive(3'd1, 4'd0, 4'b0000, 1'b0, 64'h5000, 64'd1);
    @(posedge clk); #1;
    chk("br_flush2", 64'(fl_a[1]), 64'd1);
    chk("br_wrongpath", 64'(rv_a[1]), 64'd0);
    @(posedge clk); #1;
    chk("br_flush3", 64'(fl_a[1]), 64'd1);
    chk("br_wrongpath2", 64'(rv_a[1]), 64'd0);
    #1 idle();
    @(posedge clk); #1;
    chk("br_flush_end", 64'(fl_a[1]), 64'd0);
    chk("br_brcnt", 64'(br_a[1]), 64'd1);
    #1 gap(4);

    // Asynchronous reset in the middle of a 3-cycle flush window.
    drive(3'd5, 4'd0, 4'b0000, 1'b0, 64'h0, 64'd0);
    reg_target = 64'h8000;
    go();
    idle();
    @(posedge clk); #1;
    chk("ar_pre_flush", 64'(fl_a[1]), 64'd1);
    chk("ar_pre_brcnt", 64'(br_a[1]), 64'd2);
    reset = 0;
    #1;
    chk("ar_flush", 64'(fl_a[1]), 64'd0);
    chk("ar_rv", 64'(rv_a[0]), 64'd0);
    chk("ar_brcnt", 64'(br_a[1]), 64'd0);
    chk("ar_tkcnt", 64'(tc_a[1]), 64'd0);
    go();
    reset = 1;

    // Saturation of the 4-bit counters after 17 taken branches.
    for (int i = 0; i < 17; i++) begin
      drive(3'd1, 4'd0, 4'b0000, 1'b0, 64'h100, 64'd2);
      go();
      gap(4);
    end
    chk("sat_brcnt", 64'(br_a[2]), 64'd15);
    chk("sat_tkcnt", 64'(tc_a[2]), 64'd15);
    chk("nosat_brcnt", 64'(br_a[0]), 64'd17);

    // Target wraps modulo 2^64.
    drive(3'd1, 4'd0, 4'b0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1);
    @(posedge clk); #1;
    chk("wrap_target", tgt_a[0], 64'd0);
    chk("wrap_taken", 64'(tk_a[0]), 64'd1);
    #1 gap(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
